// File: rtl/video_timing_checker.sv
// Video line/frame timing checker: measures active line length and lines per frame, flags sync/length errors.
// Optional VIDEO_RAMP_CHECK_EN adds a ramp-pattern check on in_data (data_err tied low otherwise).
//
// state     | meaning
// ST_BLANK  | between lines, waiting for in_active
// ST_ACTIVE | inside a line, counting active pixels
module video_timing_checker #(
    parameter int VIDEO_WIDTH      = 1280,
    parameter int VIDEO_DATA_WIDTH = 8,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_active,
    input  logic                        in_hsync,
    input  logic                        in_vsync,
    input  logic [VIDEO_DATA_WIDTH-1:0] in_data,
    input  logic                        err_clr,
    output logic [CNT_WIDTH-1:0]        line_len,
    output logic [CNT_WIDTH-1:0]        line_count,
    output logic [CNT_WIDTH-1:0]        frame_lines,
    output logic                        line_done,
    output logic                        frame_done,
    output logic                        len_err,
    output logic                        sync_err,
    output logic                        data_err
);

    typedef enum logic {ST_BLANK, ST_ACTIVE} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] pix_cnt;
    logic [CNT_WIDTH-1:0] lc_inc;
    logic                 armed;
    logic                 sampled;
    logic                 vsync_prev;
    logic                 line_end;
    logic                 vsync_rise;

    // A line whose start was not seen (active at reset release) is never entered.
    always_comb begin
        state_nxt  = state;
        line_end   = 1'b0;
        vsync_rise = sampled && in_vsync && !vsync_prev;
        lc_inc     = line_count;
        case (state)
            ST_BLANK: begin
                if (in_active && armed)
                    state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!in_active) begin
                    state_nxt = ST_BLANK;
                    line_end  = 1'b1;
                end
            end
            default: state_nxt = ST_BLANK;
        endcase
        if (line_end && line_count != CNT_MAX)
            lc_inc = line_count + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_BLANK;
            pix_cnt     <= '0;
            armed       <= 1'b0;
            sampled     <= 1'b0;
            vsync_prev  <= 1'b0;
            line_len    <= '0;
            line_count  <= '0;
            frame_lines <= '0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            len_err     <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            sampled    <= 1'b1;
            vsync_prev <= in_vsync;
            if (!in_active)
                armed <= 1'b1;

            if (state == ST_BLANK && state_nxt == ST_ACTIVE)
                pix_cnt <= CNT_WIDTH'(1);
            else if (state == ST_ACTIVE && in_active && pix_cnt != CNT_MAX)
                pix_cnt <= pix_cnt + 1'b1;

            line_done <= line_end;
            if (line_end)
                line_len <= pix_cnt;

            // A line ending on the vsync edge belongs to the frame being closed.
            frame_done <= vsync_rise;
            if (vsync_rise) begin
                frame_lines <= lc_inc;
                line_count  <= '0;
            end else begin
                line_count  <= lc_inc;
            end

            len_err  <= (line_end && pix_cnt != CNT_WIDTH'(VIDEO_WIDTH)) || (len_err && !err_clr);
            sync_err <= (in_hsync != in_active) || (sync_err && !err_clr);
        end
    end

`ifdef VIDEO_RAMP_CHECK_EN
    logic [VIDEO_DATA_WIDTH-1:0] data_prev;
    logic                        ramp_miss;

    assign ramp_miss = sampled && (in_data != VIDEO_DATA_WIDTH'(data_prev + 1'b1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_prev <= '0;
            data_err  <= 1'b0;
        end else begin
            data_prev <= in_data;
            data_err  <= ramp_miss || (data_err && !err_clr);
        end
    end
`else
    logic unused_data;
    assign unused_data = ^in_data;
    assign data_err    = 1'b0;
`endif

endmodule

// File: tb/tb_video_timing_checker.sv
// Self-checking bench for video_timing_checker: cycle model plus directed literal checks.
// Build with VIDEO_RAMP_CHECK_EN defined to exercise the ramp data check as well.
module tb_video_timing_checker;

    localparam int W    = 1280;
    localparam int MAXC = 65535;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_active, in_hsync, in_vsync, err_clr;
    logic [7:0]  in_data;
    logic [15:0] line_len, line_count, frame_lines;
    logic        line_done, frame_done, len_err, sync_err, data_err;

    int tests  = 0;
    int failed = 0;
    int n_ld   = 0;
    int n_fd   = 0;
    bit skip   = 1'b0;

    video_timing_checker #(.VIDEO_WIDTH(W), .VIDEO_DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_active(in_active), .in_hsync(in_hsync),
        .in_vsync(in_vsync), .in_data(in_data), .err_clr(err_clr),
        .line_len(line_len), .line_count(line_count), .frame_lines(frame_lines),
        .line_done(line_done), .frame_done(frame_done), .len_err(len_err),
        .sync_err(sync_err), .data_err(data_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: run length of active samples, line/frame bookkeeping.
    int   m_run, m_len, m_lc, m_fl;
    bit   m_inline, m_arm, m_seen, m_vsp;
    bit   m_ld, m_fd, m_le, m_se, m_de;
    logic [7:0] m_pd;

    always @(posedge clk or posedge rst) begin
        bit ended;
        bit rise;
        if (rst) begin
            m_run = 0; m_len = 0; m_lc = 0; m_fl = 0;
            m_inline = 0; m_arm = 0; m_seen = 0; m_vsp = 0;
            m_ld = 0; m_fd = 0; m_le = 0; m_se = 0; m_de = 0; m_pd = 8'd0;
        end else begin
            ended = 0;
            m_ld  = 0;
            m_fd  = 0;
            if (in_active) begin
                if (m_inline)
                    m_run = (m_run < MAXC) ? m_run + 1 : MAXC;
                else if (m_arm) begin
                    m_inline = 1;
                    m_run    = 1;
                end
            end else begin
                if (m_inline) begin
                    ended    = 1;
                    m_inline = 0;
                    m_len    = m_run;
                    m_ld     = 1;
                    m_lc     = (m_lc < MAXC) ? m_lc + 1 : MAXC;
                end
                m_arm = 1;
            end
            m_le = (ended && m_len != W) || (m_le && !err_clr);
            m_se = (in_hsync != in_active) || (m_se && !err_clr);
            rise = m_seen && in_vsync && !m_vsp;
            if (rise) begin
                m_fl = m_lc;
                m_lc = 0;
                m_fd = 1;
            end
`ifdef VIDEO_RAMP_CHECK_EN
            m_de = (m_seen && in_data != 8'((m_pd + 8'd1) % 256)) || (m_de && !err_clr);
`else
            m_de = 0;
`endif
            m_pd   = in_data;
            m_vsp  = in_vsync;
            m_seen = 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("line_len",    line_len,    m_len);
            check("line_count",  line_count,  m_lc);
            check("frame_lines", frame_lines, m_fl);
            check("line_done",   line_done,   m_ld);
            check("frame_done",  frame_done,  m_fd);
            check("len_err",     len_err,     m_le);
            check("sync_err",    sync_err,    m_se);
            check("data_err",    data_err,    m_de);
            if (line_done)  n_ld++;
            if (frame_done) n_fd++;
        end
    end

    task automatic step(input logic a, input logic h);
        @(negedge clk);
        in_active = a;
        in_hsync  = h;
        err_clr   = 1'b0;
        in_data   = in_data + (skip ? 8'd2 : 8'd1);
        skip      = 1'b0;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic line(input int n, input int glitch_at);
        for (int i = 0; i < n; i++) step(1'b1, (i == glitch_at) ? 1'b0 : 1'b1);
    endtask

    task automatic zero_pulse_counts();
        #1;
        n_ld = 0;
        n_fd = 0;
    endtask

    initial begin
        rst = 1'b1; in_active = 1'b0; in_hsync = 1'b0; in_vsync = 1'b1;
        err_clr = 1'b0; in_data = 8'd0;
        #1;
        check("rst_line_len", line_len, 0);
        check("rst_line_done", line_done, 0);
        check("rst_len_err", len_err, 0);
        blank(3);
        rst = 1'b0;

        // vsync already high at release must not count as an edge
        zero_pulse_counts();
        blank(5);
        #1;
        check("vsync_at_release_no_frame_done", n_fd, 0);
        in_vsync = 1'b0;

        // nominal line
        zero_pulse_counts();
        blank(100); line(W, -1); blank(3);
        #1;
        check("nominal_line_len", line_len, 1280);
        check("nominal_line_done_pulses", n_ld, 1);
        check("nominal_len_err", len_err, 0);
        check("nominal_sync_err", sync_err, 0);

        // short line, then clear
        blank(100); line(W - 1, -1); blank(3);
        #1;
        check("short_line_len", line_len, 1279);
        check("short_len_err", len_err, 1);
        step(1'b0, 1'b0); err_clr = 1'b1;
        blank(2);
        #1;
        check("short_len_err_cleared", len_err, 0);
        check("lines_before_frame", line_count, 2);

        // frame boundary then four lines and another boundary
        in_vsync = 1'b1; blank(3); in_vsync = 1'b0; blank(2);
        zero_pulse_counts();
        for (int k = 0; k < 4; k++) begin
            blank(100); line(W, -1);
        end
        blank(5);
        in_vsync = 1'b1; blank(3);
        #1;
        check("frame_lines_4", frame_lines, 4);
        check("frame_line_count_0", line_count, 0);
        check("frame_done_pulses", n_fd, 1);
        in_vsync = 1'b0;

        // hsync glitch inside the line
        blank(100); line(W, 500); blank(3);
        #1;
        check("glitch_sync_err", sync_err, 1);
        check("glitch_line_len", line_len, 1280);
        step(1'b0, 1'b0); err_clr = 1'b1;
        blank(2);
        #1;
        check("glitch_sync_err_cleared", sync_err, 0);

        // line end coincident with vsync edge
        blank(100); line(W, -1);
        step(1'b0, 1'b0); in_vsync = 1'b1;
        blank(3);
        #1;
        check("coincident_frame_lines", frame_lines, 2);
        check("coincident_line_count", line_count, 0);
        in_vsync = 1'b0;

        // vsync edge in the middle of a line
        blank(100);
        zero_pulse_counts();
        line(600, -1); in_vsync = 1'b1;
        line(W - 600, -1); blank(3); in_vsync = 1'b0;
        #1;
        check("midline_vsync_line_len", line_len, 1280);
        check("midline_vsync_frame_done", n_fd, 1);
        check("midline_vsync_frame_lines", frame_lines, 0);
        check("midline_vsync_line_count", line_count, 1);

`ifdef VIDEO_RAMP_CHECK_EN
        blank(300);
        #1;
        check("ramp_wrap_ok", data_err, 0);
        skip = 1'b1; blank(3);
        #1;
        check("ramp_skip_err", data_err, 1);
        skip = 1'b1; step(1'b0, 1'b0); err_clr = 1'b1;
        blank(2);
        #1;
        check("ramp_err_beats_clear", data_err, 1);
        step(1'b0, 1'b0); err_clr = 1'b1;
        blank(2);
        #1;
        check("ramp_err_cleared", data_err, 0);
`endif

        // reset in the middle of a line
        blank(100); line(600, -1);
        rst = 1'b1;
        #1;
        check("midreset_line_len", line_len, 0);
        check("midreset_line_count", line_count, 0);
        check("midreset_frame_lines", frame_lines, 0);
        check("midreset_flags", {line_done, frame_done, len_err, sync_err, data_err}, 0);
        line(5, -1);
        step(1'b0, 1'b0); rst = 1'b0;
        zero_pulse_counts();
        blank(100); line(W, -1); blank(3);
        #1;
        check("postreset_line_len", line_len, 1280);
        check("postreset_line_count", line_count, 1);
        check("postreset_line_done_pulses", n_ld, 1);

        blank(5);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
